// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full adder and one carry flop, LSB first,
// one result bit per clock, with an IDLE/RUN/DONE control FSM.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic fa_sum;
    logic fa_carry;
    logic last_bit;

    assign fa_sum   = a_q[0] ^ b_q[0] ^ carry_q;
    assign fa_carry = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        busy      = (state_q == S_RUN);
        done      = (state_q == S_DONE);
        dbg_state = state_q;
    end

    // Datapath next-state: subtraction is A + ~B + 1, so cout=1 means no borrow
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                a_d              = a_q >> 1;
                b_d              = b_q >> 1;
                acc_d            = acc_q >> 1;
                acc_d[WIDTH-1]   = fa_sum;
                carry_d          = fa_carry;
                cnt_d            = cnt_q + CW'(1);
                if (last_bit) begin
                    // carry_q here is the carry into the MSB
                    sum_d  = acc_d;
                    cout_d = fa_carry;
                    ovf_d  = carry_q ^ fa_carry;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=1 instances,
// scoreboard queues filled at start and drained on done.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       start8, cin8, sub8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;
    logic [1:0] st8;

    logic start1, a1, b1, cin1, sub1;
    logic busy1, done1, sum1, cout1, ovf1;
    logic [1:0] st1;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8),
        .dbg_state(st8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1),
        .dbg_state(st1)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [9:0] exp_q8[$];
    logic [2:0] exp_q1[$];
    logic [9:0] last8;
    logic [2:0] last1;
    logic [9:0] pop8;
    logic [2:0] pop1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns {overflow, cout, sum} from plain arithmetic
    function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b,
                                          input logic cin, input logic sub);
        logic [8:0] full;
        logic [7:0] s;
        logic       c, v;
        if (!sub) begin
            full = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            s    = full[7:0];
            c    = full[8];
            v    = (a[7] == b[7]) && (s[7] != a[7]);
        end else begin
            s = a - b;
            c = (a >= b);
            v = (a[7] != b[7]) && (s[7] != a[7]);
        end
        return {v, c, s};
    endfunction

    function automatic logic [2:0] model1(input logic a, input logic b,
                                          input logic cin, input logic sub);
        logic [1:0] full;
        logic       s, c, v;
        if (!sub) begin
            full = {1'b0, a} + {1'b0, b} + {1'b0, cin};
            s    = full[0];
            c    = full[1];
            v    = (a == b) && (s != a);
        end else begin
            s = a ^ b;
            c = (a >= b);
            v = (a != b) && (s != a);
        end
        return {v, c, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: every done pulse must match a queued expectation
    always @(negedge clk) begin
        if (done8) begin
            if (exp_q8.size() == 0) begin
                check("done8_unexpected", 1, 0);
            end else begin
                pop8 = exp_q8.pop_front();
                check("res8", {ovf8, cout8, sum8}, pop8);
            end
        end
        if (done1) begin
            if (exp_q1.size() == 0) begin
                check("done1_unexpected", 1, 0);
            end else begin
                pop1 = exp_q1.pop_front();
                check("res1", {ovf1, cout1, sum1}, pop1);
            end
        end
    end

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub, input bit glitch);
        logic [9:0] e;
        e      = model8(a, b, cin, sub);
        a8     = a;
        b8     = b;
        cin8   = cin;
        sub8   = sub;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        exp_q8.push_back(e);
        for (int k = 1; k <= 8; k++) begin
            check("busy8_run", busy8, 1);
            check("done8_run", done8, 0);
            check("hold8_run", {ovf8, cout8, sum8}, last8);
            if (glitch) begin
                a8     = 8'($urandom_range(0, 255));
                b8     = 8'($urandom_range(0, 255));
                cin8   = 1'($urandom_range(0, 1));
                sub8   = 1'($urandom_range(0, 1));
                start8 = (k == 3);
            end
            tick();
            start8 = 1'b0;
        end
        check("busy8_at_done", busy8, 0);
        check("done8_pulse", done8, 1);
        check("out8_at_done", {ovf8, cout8, sum8}, e);
        last8 = e;
        if (glitch) begin
            a8     = ~a;
            b8     = ~b;
            start8 = 1'b1;
        end
        tick();
        start8 = 1'b0;
        check("done8_one_cycle", done8, 0);
        check("busy8_idle", busy8, 0);
        check("hold8_idle", {ovf8, cout8, sum8}, last8);
    endtask

    task automatic run1(input logic a, input logic b, input logic cin, input logic sub);
        logic [2:0] e;
        e      = model1(a, b, cin, sub);
        a1     = a;
        b1     = b;
        cin1   = cin;
        sub1   = sub;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        exp_q1.push_back(e);
        check("busy1_run", busy1, 1);
        check("hold1_run", {ovf1, cout1, sum1}, last1);
        tick();
        check("done1_pulse", done1, 1);
        check("busy1_at_done", busy1, 0);
        last1 = e;
        tick();
        check("done1_one_cycle", done1, 0);
    endtask

    initial begin
        rst    = 1'b1;
        start8 = 1'b1;
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; sub8 = 1'b0;
        start1 = 1'b1;
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; sub1 = 1'b0;
        last8 = '0;
        last1 = '0;
        #1;
        check("rst8_outputs", {busy8, done8, ovf8, cout8, sum8}, 12'h000);
        check("rst1_outputs", {busy1, done1, ovf1, cout1, sum1}, 5'h00);
        tick();
        tick();
        check("rst8_start_ignored", busy8, 0);
        check("rst1_start_ignored", busy1, 0);
        rst    = 1'b0;
        start8 = 1'b0;
        start1 = 1'b0;

        run8(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);
        run8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        run8(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        run8(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
        run8(8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
        run8(8'h80, 8'h01, 1'b1, 1'b1, 1'b0);
        // Restart attempts while busy and in DONE, then back-to-back at earliest edge
        run8(8'h3C, 8'h5A, 1'b1, 1'b0, 1'b1);
        run8(8'hA5, 8'h5A, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of RUN
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; sub8 = 1'b0;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", {busy8, done8, ovf8, cout8, sum8}, 12'h000);
        last8  = '0;
        last1  = '0;
        start8 = 1'b1;
        tick();
        tick();
        check("rst_mid_start_ignored", {busy8, done8}, 2'b00);
        rst    = 1'b0;
        start8 = 1'b0;
        run8(8'hC8, 8'h64, 1'b1, 1'b0, 1'b0);
        run8(8'h01, 8'h02, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            run1(v[3], v[2], v[1], v[0]);
        end

        tick();
        check("q8_drained", 64'(exp_q8.size()), 0);
        check("q1_drained", 64'(exp_q1.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
